// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and byte selection for the UART sample framer.
package uart_frame_pkg;

    localparam int unsigned FRAME_LEN    = 4;
    localparam logic [7:0]  DEFAULT_SYNC = 8'hA5;
    localparam int unsigned BYTE_IDX_W   = $clog2(FRAME_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO
    } framer_state_t;

    // Frame layout: SYNC, HI, LO, CHK (HI ^ LO) of the sign-extended sample.
    function automatic logic [7:0] frame_byte(input logic [15:0]           x,
                                              input logic [7:0]            sync,
                                              input logic [BYTE_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sync;
            2'd1:    b = x[15:8];
            2'd2:    b = x[7:0];
            default: b = x[15:8] ^ x[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_sample_framer_sync_fifo.sv
// Single-clock FIFO with occupancy output; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (level_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/uart_sample_framer.sv
// Buffers filtered samples and serialises each into a SYNC/HI/LO/CHK frame
// for the byte-level UART transmitter, one byte per tx_start/tx_busy handshake.
module uart_sample_framer
    import uart_frame_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    framer_state_t           state_q, state_d;
    logic [BYTE_IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]             frame_q, frame_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    frame_done_q, frame_done_d;
    logic                    rdy_en_q;
    logic [DATA_W-1:0]       fifo_rd;
    logic [LW-1:0]           level;
    logic                    push, pop;

    // rdy_en_q holds s_ready low for the first cycle after reset release.
    assign s_ready = rdy_en_q && (level != LW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (s_data),
        .rd_data_o (fifo_rd),
        .level_o   (level)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((level != '0) && !tx_busy) begin
                    pop     = 1'b1;
                    frame_d = 16'($signed(fifo_rd));
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d  = frame_byte(frame_q, SYNC_BYTE, idx_q);
                tx_start_d = 1'b1;
                state_d    = ST_START;
            end
            ST_START: state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_busy) state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == BYTE_IDX_W'(FRAME_LEN - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + BYTE_IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
            rdy_en_q     <= 1'b1;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;
    assign fifo_level = level;

endmodule

// File: doc/uart_sample_framer.md
Name: uart_sample_framer

Overview:
Upstream neighbour of the UART transmitter. Accepts filtered output samples from the Wiener filter datapath over a valid/ready stream and buffers them in a small FIFO. Each sample is serialised into a fixed 4-byte frame: SYNC, HI, LO, CHK. Bytes are handed to the byte-level UART transmitter through its tx_start/tx_busy handshake, one at a time.

Parameters:
DATA_W, 16, sample width; legal 9..16; sample is sign-extended to 16 bits before framing
FIFO_DEPTH, 16, sample FIFO entries; power of 2, >= 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock (25 MHz in the reference build)
reset  in  1  asynchronous, active-high reset
s_valid  in  1  upstream sample valid
s_data  in  DATA_W  upstream sample, two's complement
s_ready  out  1  FIFO can accept; a transfer occurs when s_valid && s_ready at posedge clk
tx_start  out  1  one-cycle request to the UART transmitter; registered
tx_data  out  8  byte to transmit; registered; stable from the tx_start cycle until the next tx_start
tx_busy  in  1  UART transmitter busy; rises the cycle after an accepted tx_start, falls after the stop bit
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_done  out  1  one-cycle pulse when tx_busy falls after the CHK byte

Behaviour:
- Reset (asynchronous, active-high) clears all state; must be honoured mid-frame.
  - Reset values: tx_start=0, tx_data=8'h00, frame_done=0, fifo_level=0, s_ready=0.
  - s_ready rises on the first clock after reset deasserts.
  - The FIFO is emptied and a partially sent frame is abandoned; no completion of a partial frame after reset.
- FIFO:
  - s_ready = (fifo_level != FIFO_DEPTH), combinational from the registered level.
  - Simultaneous push and pop when full: permitted only as a pop, because s_ready is low. Level is unchanged.
  - Simultaneous push and pop when neither full nor empty: level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - First-word latency: a sample written at edge N is visible to the FSM at edge N+1.
- Frame bytes, with x = sign-extended 16-bit sample:
  - SYNC = SYNC_BYTE
  - HI = x[15:8]
  - LO = x[7:0]
  - CHK = HI ^ LO
- FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO.
  - IDLE: if fifo_level != 0 and tx_busy == 0, pop one sample into the frame register, set byte_idx = 0, go to LOAD.
  - LOAD: drive tx_data with the byte selected by byte_idx, go to START.
  - START: tx_start = 1 for exactly this cycle, go to WAIT_HI.
  - WAIT_HI: stay until tx_busy == 1, then go to WAIT_LO.
  - WAIT_LO: stay until tx_busy == 0.
    - If byte_idx == 3: pulse frame_done, go to IDLE.
    - Otherwise: byte_idx += 1, go to LOAD.
- tx_start is never asserted while tx_busy == 1; at most one tx_start per byte.
- Frames are never interleaved. A new pop happens only in IDLE.
- Inter-byte gap on the UART side is at most 3 clk cycles.
- Back-to-back frames: IDLE may pop in the same cycle frame_done pulses' successor. Throughput is bound by the UART, not the framer.

Decomposition:
- Shared package uart_frame_pkg:
  - FRAME_LEN = 4
  - DEFAULT_SYNC = 8'hA5
  - framer state encoding typedef
  - byte-index width constant
- One natural sub-module: sync_fifo (parameterised width/depth, async reset, push/pop/level). The framer FSM and byte mux stay in the top.

Test Plan:
- Single sample 16'h1234, tx_busy modelled as real UART (10 bit-times) -> bytes A5,12,34,26 in order; exactly 4 tx_start pulses; one frame_done.
- DATA_W=12, sample 12'h800 -> HI=F8, LO=00, CHK=F8 (sign extension checked).
- Hold tx_busy=1 externally, push 20 samples continuously -> 16 accepted, s_ready low from the 17th, fifo_level=16. Release -> 16 frames sent in FIFO order, no drops or duplicates.
- Push while popping at level 5 -> level stays 5; frame order preserved.
- Assert reset during WAIT_LO of the HI byte -> tx_start=0 and fifo_level=0 immediately (asynchronously). No further tx_start until a new sample arrives after reset release.
- Stuck-low check: tx_busy never rises after tx_start -> FSM holds in WAIT_HI; no second tx_start issued.
